// File: rtl/imem_prog_loader_if.sv
// ---------------------------------------------------------------------------
// imem_prog_loader_if
//
// Bundles the two buses the program loader sits between:
//   - the byte-serial program stream (valid/ready handshake)
//   - the instruction-memory write port
//
// Signals:
//   in_data    [7:0]        program stream byte
//   in_valid                in_data valid
//   in_ready                loader can accept a byte this cycle
//   imem_we                 instruction memory write enable (1-cycle pulse)
//   imem_addr  [ADDR_W-1:0] word address for the write
//   imem_wdata [31:0]       instruction word
//
// Modports:
//   master - the environment: drives the byte stream, observes the write port
//   slave  - the loader: consumes the byte stream, drives the write port
// ---------------------------------------------------------------------------
interface imem_prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_prog_loader.sv
// ---------------------------------------------------------------------------
// imem_prog_loader
//
// Receives a byte-serial program image, packs it into 32-bit little-endian
// instruction words, writes them into instruction memory and releases the
// core from reset only once the whole image has arrived with a good checksum.
//
// Stream format: N[7:0], N[15:8], then 4*N data bytes (first byte of each
// word lands in bits [7:0]), then one checksum byte = XOR of the data bytes.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   start     begin a load (honoured only when no load is in progress)
//   bus       imem_prog_loader_if.slave: byte stream in, imem write port out
//   core_rst  held-in-reset request to the core (low only after a good load)
//   busy      load in progress
//   done      load completed, checksum good
//   error     load aborted: bad length or checksum mismatch
// ---------------------------------------------------------------------------
module imem_prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_prog_loader_if.slave   bus,
    output logic                core_rst,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    // Number of words the memory can hold; a length equal to this is legal.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    state_t            state;
    state_t            next_state;
    logic [15:0]       len;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       word_buf;
    logic [7:0]        checksum;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              xfer;
    logic [15:0]       len_full;
    logic              len_bad;
    logic              last_word;

    // in_ready depends on state only, so xfer never feeds back into in_ready.
    assign xfer      = bus.in_valid && bus.in_ready;
    assign len_full  = {bus.in_data, len[7:0]};
    assign len_bad   = (len_full == 16'd0) || ({17'd0, len_full} > CAPACITY);
    // Compared in a wide domain so a full-capacity load never wraps word_idx.
    assign last_word = (33'(word_idx) == (33'(len) - 33'd1));

    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs; core_rst is released only while in DONE.
    always_comb begin
        next_state   = state;
        bus.in_ready = 1'b0;
        bus.imem_we  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        core_rst     = 1'b1;
        case (state)
            IDLE: begin
                if (start) next_state = LEN0;
            end
            LEN0: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (xfer) next_state = LEN1;
            end
            LEN1: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (xfer) next_state = len_bad ? ERR : DATA;
            end
            DATA: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (xfer && (byte_idx == 2'd3)) next_state = WRITE;
            end
            WRITE: begin
                bus.imem_we = 1'b1;
                busy        = 1'b1;
                next_state  = last_word ? CHK : DATA;
            end
            CHK: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (xfer) next_state = (bus.in_data == checksum) ? DONE : ERR;
            end
            DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
                if (start) next_state = LEN0;
            end
            ERR: begin
                error = 1'b1;
                if (start) next_state = LEN0;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: length capture, byte packing, checksum and write-port
    // registers. The write address/data are captured with the 4th byte so
    // they are valid during WRITE and simply hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            len      <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            word_buf <= '0;
            checksum <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        len      <= '0;
                        byte_idx <= '0;
                        word_idx <= '0;
                        checksum <= '0;
                    end
                end
                LEN0: begin
                    if (xfer) len[7:0] <= bus.in_data;
                end
                LEN1: begin
                    if (xfer) begin
                        len[15:8] <= bus.in_data;
                        byte_idx  <= '0;
                        word_idx  <= '0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        checksum <= checksum ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.in_data;
                            2'd1: word_buf[15:8]  <= bus.in_data;
                            2'd2: word_buf[23:16] <= bus.in_data;
                            default: begin
                                addr_q  <= word_idx;
                                wdata_q <= {bus.in_data, word_buf};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (!last_word) word_idx <= word_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_prog_loader
//
// Drives program images into the loader and compares its outputs every cycle
// against a stream-position model of the loader, plus literal expectations
// for the hand-worked images.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_prog_loader;

    localparam int ADDR_W = 4;
    localparam int CAP    = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic core_rst;
    logic busy;
    logic done;
    logic error;

    imem_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.slave),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];

    // Model state, expressed as position within the byte stream.
    bit                m_active = 1'b0;
    bit                m_done   = 1'b0;
    bit                m_err    = 1'b0;
    bit                m_wpend  = 1'b0;
    int                m_pos    = 0;
    int                m_n      = 0;
    logic [7:0]        m_csum   = '0;
    logic [31:0]       m_word   = '0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [31:0]       m_wdata  = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // The model advances one step per clock: a pending write occupies a
    // cycle, otherwise an accepted byte is classified by its stream position.
    always @(posedge clk) begin : model
        int k;
        logic [7:0] b;
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_wpend = 1'b0;
            m_pos = 0; m_n = 0; m_csum = '0; m_word = '0; m_addr = '0; m_wdata = '0;
        end else if (m_wpend) begin
            m_wpend = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_done = 1'b0; m_err = 1'b0;
                m_pos = 0; m_n = 0; m_csum = '0;
            end
        end else if (bus.in_valid) begin
            b = bus.in_data;
            m_pos++;
            if (m_pos == 1) begin
                m_n = int'(b);
            end else if (m_pos == 2) begin
                m_n = m_n + (int'(b) << 8);
                if (m_n == 0 || m_n > CAP) begin
                    m_active = 1'b0;
                    m_err    = 1'b1;
                end
            end else if (m_pos <= 2 + 4 * m_n) begin
                k = m_pos - 3;
                m_word[8*(k%4) +: 8] = b;
                m_csum = m_csum ^ b;
                if (k % 4 == 3) begin
                    m_wpend = 1'b1;
                    m_addr  = ADDR_W'(k / 4);
                    m_wdata = m_word;
                end
            end else begin
                m_active = 1'b0;
                if (b == m_csum) m_done = 1'b1;
                else m_err = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("in_ready",   32'(bus.in_ready),   32'(m_active && !m_wpend));
            checkOutput("imem_we",    32'(bus.imem_we),    32'(m_wpend));
            checkOutput("imem_addr",  32'(bus.imem_addr),  32'(m_addr));
            checkOutput("imem_wdata", bus.imem_wdata,      m_wdata);
            checkOutput("busy",       32'(busy),           32'(m_active));
            checkOutput("done",       32'(done),           32'(m_done));
            checkOutput("error",      32'(error),          32'(m_err));
            checkOutput("core_rst",   32'(core_rst),       32'(!m_done));
            if (bus.imem_we === 1'b1) begin
                log_addr.push_back(bus.imem_addr);
                log_data.push_back(bus.imem_wdata);
            end
        end
    end

    function automatic byte_q_t buildImage(input int n, input int seed, input bit corrupt);
        byte_q_t q;
        logic [7:0] cs;
        logic [7:0] b;
        cs = '0;
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'(i * 37 + seed);
            q.push_back(b);
            cs = cs ^ b;
        end
        q.push_back(corrupt ? ~cs : cs);
        return q;
    endfunction

    // Present one byte and hold it until accepted, optionally idling first.
    task automatic sendByte(input logic [7:0] b, input bit gaps);
        bit accepted;
        int budget;
        accepted = 1'b0;
        budget   = 100;
        if (gaps && ($urandom_range(1, 0) == 1)) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!accepted && budget > 0) begin
            accepted = (bus.in_ready === 1'b1);
            @(negedge clk);
            budget--;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: byte 0x%0h not accepted in 100 cycles, expected acceptance", b);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy",     32'(busy),     32'd1);
        checkOutput("start_core_rst", 32'(core_rst), 32'd1);
    endtask

    // Start a load and feed a whole image (or its first 'count' bytes).
    task automatic applyStimulus(input byte_q_t img, input bit gaps, input int count);
        log_addr.delete();
        log_data.delete();
        pulseStart();
        for (int i = 0; i < count; i++) sendByte(img[i], gaps);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Writes captured from the DUT must be the image's words at 0..N-1.
    task automatic checkLog(input string tag, input byte_q_t img);
        int n;
        n = int'(img[0]) | (int'(img[1]) << 8);
        checkOutput({tag, "_count"}, 32'(log_addr.size()), 32'(n));
        for (int k = 0; k < n && k < log_addr.size(); k++) begin
            checkOutput({tag, "_addr"}, 32'(log_addr[k]), 32'(k));
            checkOutput({tag, "_data"}, log_data[k],
                        {img[2+4*k+3], img[2+4*k+2], img[2+4*k+1], img[2+4*k]});
        end
    endtask

    initial begin
        byte_q_t img_a;
        byte_q_t img_b;
        byte_q_t img_z;
        byte_q_t img_4;
        byte_q_t img_16;

        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("rst_core_rst", 32'(core_rst),       32'd1);
        checkOutput("rst_busy",     32'(busy),           32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready),   32'd0);
        checkOutput("rst_wdata",    bus.imem_wdata,      32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-word image; XOR of 13,00,00,00,93,00,10,00 is 0x90.
        img_a = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        applyStimulus(img_a, 1'b0, img_a.size());
        checkOutput("a_count", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            checkOutput("a_addr0", 32'(log_addr[0]), 32'd0);
            checkOutput("a_data0", log_data[0], 32'h0000_0013);
            checkOutput("a_addr1", 32'(log_addr[1]), 32'd1);
            checkOutput("a_data1", log_data[1], 32'h0010_0093);
        end
        checkOutput("a_done",     32'(done),     32'd1);
        checkOutput("a_error",    32'(error),    32'd0);
        checkOutput("a_core_rst", 32'(core_rst), 32'd0);

        // Same words, wrong checksum: writes still happen, load fails.
        img_b = img_a;
        img_b[10] = 8'h81;
        applyStimulus(img_b, 1'b0, img_b.size());
        checkLog("b", img_b);
        checkOutput("b_error",    32'(error),    32'd1);
        checkOutput("b_done",     32'(done),     32'd0);
        checkOutput("b_core_rst", 32'(core_rst), 32'd1);

        // Illegal lengths: 0, 257 and capacity+1 abort after the length bytes.
        img_z = '{8'h00, 8'h00};
        applyStimulus(img_z, 1'b0, 2);
        checkOutput("len0_writes", 32'(log_addr.size()), 32'd0);
        checkOutput("len0_error",  32'(error),           32'd1);
        img_z = '{8'h01, 8'h01};
        applyStimulus(img_z, 1'b0, 2);
        checkOutput("len257_writes", 32'(log_addr.size()), 32'd0);
        checkOutput("len257_error",  32'(error),           32'd1);
        img_z = '{8'(CAP + 1), 8'h00};
        applyStimulus(img_z, 1'b0, 2);
        checkOutput("lencap1_writes", 32'(log_addr.size()), 32'd0);
        checkOutput("lencap1_error",  32'(error),           32'd1);

        // Four words with random valid gaps, then the same image gap-free.
        img_4 = buildImage(4, 11, 1'b0);
        applyStimulus(img_4, 1'b1, img_4.size());
        checkLog("gap", img_4);
        checkOutput("gap_done", 32'(done), 32'd1);
        applyStimulus(img_4, 1'b0, img_4.size());
        checkLog("nogap", img_4);
        checkOutput("nogap_done", 32'(done), 32'd1);

        // Reset after two of four words have been written.
        applyStimulus(img_4, 1'b0, 10);
        checkOutput("mid_writes_before", 32'(log_addr.size()), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_busy",     32'(busy),     32'd0);
        checkOutput("mid_done",     32'(done),     32'd0);
        checkOutput("mid_core_rst", 32'(core_rst), 32'd1);
        repeat (6) @(negedge clk);
        checkOutput("mid_writes_after", 32'(log_addr.size()), 32'd2);
        applyStimulus(img_4, 1'b0, img_4.size());
        checkLog("reload", img_4);
        checkOutput("reload_done", 32'(done), 32'd1);

        // Full capacity: N = 2^ADDR_W, last address all-ones.
        img_16 = buildImage(CAP, 3, 1'b0);
        applyStimulus(img_16, 1'b1, img_16.size());
        checkLog("full", img_16);
        if (log_addr.size() == CAP)
            checkOutput("full_last_addr", 32'(log_addr[CAP-1]), 32'hF);
        checkOutput("full_done", 32'(done), 32'd1);

        // Restart straight from DONE; pulseStart checks core_rst re-asserts.
        applyStimulus(img_a, 1'b1, img_a.size());
        checkLog("restart", img_a);
        checkOutput("restart_done", 32'(done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
